regfile_write_arbiter: RTL and testbench

Shares the single register-file write port among N_REQ requesters, e.g. ALU writeback, load return and multiply/divide unit. Each cycle the block grants at most one requester through a valid/ready handshake and registers the accepted write. It drives the register-file write-enable, address, data and a one-hot decoded write select one cycle later. A burst counter bounds how long one requester may keep the port; policy is round-robin or fixed priority (see Configuration).

---
 rtl/regfile_write_arbiter_if.sv | 26 ++
 rtl/regfile_write_arbiter.sv | 168 ++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Requester-side handshake and register-file write bus for regfile_write_arbiter.
// The arbiter uses the slave modport, the requesters/bench use the master modport.
interface regfile_write_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ*ADDR_W-1:0]  req_addr;
    logic [N_REQ*DATA_W-1:0]  req_data;
    logic [N_REQ-1:0]         req_ready;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic [(1<<ADDR_W)-1:0]   wr_onehot;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, wr_en, wr_addr, wr_data, wr_onehot
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, wr_en, wr_addr, wr_data, wr_onehot
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Arbitrates N_REQ writers onto one register-file write port with a burst limit.
// Define ARB_ROUND_ROBIN_EN for round-robin selection; otherwise fixed priority.
module regfile_write_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    regfile_write_arbiter_if.slave bus,
    output logic [N_REQ-1:0]      owner
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int NREG  = 1 << ADDR_W;
    localparam logic [N_REQ-1:0] REQ_LSB = {{(N_REQ-1){1'b0}}, 1'b1};
    localparam logic [NREG-1:0]  REG_LSB = {{(NREG-1){1'b0}}, 1'b1};
    localparam logic [3:0]       MAX_C   = 4'(MAX_BURST);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_OWN = 1'b1} state_t;

    state_t              fsm_r;
    logic [IDX_W-1:0]    owner_idx_r;
    logic [3:0]          count_r;
    logic [IDX_W-1:0]    idle_start_s;
    logic [IDX_W-1:0]    rel_start_s;
    logic [N_REQ-1:0]    owner_bit_s;
    logic [IDX_W:0]      pick_s;
    logic                grant_any_s;
    logic [IDX_W-1:0]    grant_idx_s;
    logic                cont_s;
    logic                accept_s;
    logic [ADDR_W-1:0]   acc_addr_s;
    logic [DATA_W-1:0]   acc_data_s;

    // First set bit of v scanning upward from start (wrapping); MSB of result = found.
    function automatic logic [IDX_W:0] pick(input logic [N_REQ-1:0] v,
                                            input logic [IDX_W-1:0] start);
        logic             found;
        logic [IDX_W-1:0] idx;
        logic             hit;
        int               j;
        found = 1'b0;
        idx   = {IDX_W{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            j     = int'(start) + k;
            j     = (j >= N_REQ) ? j - N_REQ : j;
            hit   = ~found & v[IDX_W'(j)];
            idx   = hit ? IDX_W'(j) : idx;
            found = found | v[IDX_W'(j)];
        end
        return {found, idx};
    endfunction

    assign owner_bit_s = REQ_LSB << owner_idx_r;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr_r;

    assign idle_start_s = rr_ptr_r;
    assign rel_start_s  = (owner_idx_r == IDX_W'(N_REQ-1)) ? {IDX_W{1'b0}}
                                                           : owner_idx_r + IDX_W'(1);

    // Round-robin pointer moves past the owner on every release.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            rr_ptr_r <= {IDX_W{1'b0}};
        end else if ((fsm_r == ST_OWN) && !cont_s) begin
            rr_ptr_r <= rel_start_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
`else
    // Fixed priority always scans from index 0; the old owner is masked out on release.
    assign idle_start_s = {IDX_W{1'b0}};
    assign rel_start_s  = {IDX_W{1'b0}};
`endif

    // Grant selection: continue the burst, hand over, re-grant the owner, or go idle.
    always_comb begin
        grant_any_s = 1'b0;
        grant_idx_s = {IDX_W{1'b0}};
        cont_s      = 1'b0;
        pick_s      = {(IDX_W+1){1'b0}};
        case (fsm_r)
            ST_IDLE: begin
                pick_s      = pick(bus.req_valid, idle_start_s);
                grant_any_s = pick_s[IDX_W];
                grant_idx_s = pick_s[IDX_W-1:0];
            end
            ST_OWN: begin
                if (bus.req_valid[owner_idx_r] && (count_r < MAX_C)) begin
                    grant_any_s = 1'b1;
                    grant_idx_s = owner_idx_r;
                    cont_s      = 1'b1;
                end else begin
                    pick_s = pick(bus.req_valid & ~owner_bit_s, rel_start_s);
                    if (pick_s[IDX_W]) begin
                        grant_any_s = 1'b1;
                        grant_idx_s = pick_s[IDX_W-1:0];
                    end else begin
                        grant_any_s = bus.req_valid[owner_idx_r];
                        grant_idx_s = owner_idx_r;
                    end
                end
            end
            default: begin
                grant_any_s = 1'b0;
                grant_idx_s = {IDX_W{1'b0}};
            end
        endcase
    end

    assign accept_s      = grant_any_s & ~ctrl_reset;
    assign bus.req_ready = accept_s ? (REQ_LSB << grant_idx_s) : {N_REQ{1'b0}};

    // Route the granted requester's address and data to the output register.
    always_comb begin
        acc_addr_s = {ADDR_W{1'b0}};
        acc_data_s = {DATA_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            acc_addr_s = (grant_idx_s == IDX_W'(i)) ? bus.req_addr[i*ADDR_W +: ADDR_W] : acc_addr_s;
            acc_data_s = (grant_idx_s == IDX_W'(i)) ? bus.req_data[i*DATA_W +: DATA_W] : acc_data_s;
        end
    end

    // Ownership state machine with registered one-hot owner.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            fsm_r       <= ST_IDLE;
            owner_idx_r <= {IDX_W{1'b0}};
            count_r     <= 4'd0;
            owner       <= {N_REQ{1'b0}};
        end else if (grant_any_s) begin
            fsm_r       <= ST_OWN;
            owner_idx_r <= grant_idx_s;
            count_r     <= cont_s ? count_r + 4'd1 : 4'd1;
            owner       <= REQ_LSB << grant_idx_s;
        end else begin
            fsm_r       <= ST_IDLE;
            owner_idx_r <= owner_idx_r;
            count_r     <= 4'd0;
            owner       <= {N_REQ{1'b0}};
        end
    end

    // Write port register; register 0 is hard-wired zero so its writes are suppressed.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            bus.wr_en     <= 1'b0;
            bus.wr_addr   <= {ADDR_W{1'b0}};
            bus.wr_data   <= {DATA_W{1'b0}};
            bus.wr_onehot <= {NREG{1'b0}};
        end else if (accept_s) begin
            bus.wr_en     <= (acc_addr_s != {ADDR_W{1'b0}});
            bus.wr_addr   <= acc_addr_s;
            bus.wr_data   <= acc_data_s;
            bus.wr_onehot <= (acc_addr_s != {ADDR_W{1'b0}}) ? (REG_LSB << acc_addr_s)
                                                            : {NREG{1'b0}};
        end else begin
            bus.wr_en     <= 1'b0;
            bus.wr_addr   <= bus.wr_addr;
            bus.wr_data   <= bus.wr_data;
            bus.wr_onehot <= {NREG{1'b0}};
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (MAX_BURST=4 and MAX_BURST=1 instances).
module tb_regfile_write_arbiter;
    logic clock;
    logic ctrl_reset;
    logic [3:0] owner_a;
    logic [3:0] owner_b;
    int checks;
    int errors;

    regfile_write_arbiter_if #(.N_REQ(4), .ADDR_W(5), .DATA_W(32)) bus_a ();
    regfile_write_arbiter_if #(.N_REQ(4), .ADDR_W(5), .DATA_W(32)) bus_b ();

    regfile_write_arbiter #(.N_REQ(4), .ADDR_W(5), .DATA_W(32), .MAX_BURST(4)) dut (
        .clock(clock), .ctrl_reset(ctrl_reset), .bus(bus_a), .owner(owner_a));

    regfile_write_arbiter #(.N_REQ(4), .ADDR_W(5), .DATA_W(32), .MAX_BURST(1)) dut_b1 (
        .clock(clock), .ctrl_reset(ctrl_reset), .bus(bus_b), .owner(owner_b));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_a(input int i, input logic [4:0] a, input logic [31:0] d);
        bus_a.req_addr[i*5 +: 5]   = a;
        bus_a.req_data[i*32 +: 32] = d;
    endtask

    task automatic test_reset();
        ctrl_reset = 1'b1;
        bus_a.req_valid = 4'b1111;
        #12;
        checks++;
        if (bus_a.wr_en !== 1'b0 || owner_a !== 4'b0000 || bus_a.wr_onehot !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: wr_en=%b owner=%b onehot=%h expected 0/0000/0",
                     bus_a.wr_en, owner_a, bus_a.wr_onehot);
        end
        checks++;
        if (bus_a.req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 0000", bus_a.req_ready);
        end
        @(negedge clock);
        ctrl_reset = 1'b0;
        bus_a.req_valid = 4'b0001;
        set_a(0, 5'd9, 32'h0000_0099);
        tick();
        checks++;
        if (bus_a.wr_en !== 1'b1 || bus_a.wr_addr !== 5'd9) begin
            errors++;
            $display("FAIL pre_reset_write: wr_en=%b addr=%0d expected 1/9", bus_a.wr_en, bus_a.wr_addr);
        end
        ctrl_reset = 1'b1;
        #1;
        checks++;
        if (bus_a.wr_en !== 1'b0 || owner_a !== 4'b0000 || bus_a.req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset: wr_en=%b owner=%b ready=%b expected 0/0000/0000",
                     bus_a.wr_en, owner_a, bus_a.req_ready);
        end
        bus_a.req_valid = 4'b0010;
        set_a(1, 5'd2, 32'h0000_0022);
        #2;
        ctrl_reset = 1'b0;
        #1;
        checks++;
        if (bus_a.req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL post_reset_ready: got %b expected 0010", bus_a.req_ready);
        end
        tick();
        checks++;
        if (owner_a !== 4'b0010) begin
            errors++;
            $display("FAIL post_reset_owner: got %b expected 0010", owner_a);
        end
        bus_a.req_valid = 4'b0000;
        tick();
        checks++;
        if (owner_a !== 4'b0000) begin
            errors++;
            $display("FAIL idle_owner: got %b expected 0000", owner_a);
        end
    endtask

    task automatic test_single();
        bus_a.req_valid = 4'b0001;
        set_a(0, 5'd3, 32'hDEAD_BEEF);
        tick();
        bus_a.req_valid = 4'b0000;
        checks++;
        if (bus_a.wr_en !== 1'b1 || bus_a.wr_addr !== 5'd3 || bus_a.wr_data !== 32'hDEAD_BEEF
            || bus_a.wr_onehot !== 32'h0000_0008) begin
            errors++;
            $display("FAIL single_write: en=%b addr=%0d data=%h onehot=%h expected 1/3/deadbeef/00000008",
                     bus_a.wr_en, bus_a.wr_addr, bus_a.wr_data, bus_a.wr_onehot);
        end
        tick();
        checks++;
        if (bus_a.wr_en !== 1'b0 || bus_a.wr_onehot !== 32'h0 || bus_a.wr_addr !== 5'd3) begin
            errors++;
            $display("FAIL single_idle: en=%b onehot=%h addr=%0d expected 0/0/3",
                     bus_a.wr_en, bus_a.wr_onehot, bus_a.wr_addr);
        end
    endtask

    task automatic test_burst_limit();
        bus_a.req_valid = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            set_a(2, 5'(10 + k), 32'hA000_0000 + 32'(k));
            #1;
            checks++;
            if (bus_a.req_ready !== 4'b0100) begin
                errors++;
                $display("FAIL burst_ready[%0d]: got %b expected 0100", k, bus_a.req_ready);
            end
            tick();
            checks++;
            if (bus_a.wr_en !== 1'b1 || bus_a.wr_addr !== 5'(10 + k)
                || bus_a.wr_data !== 32'hA000_0000 + 32'(k) || owner_a !== 4'b0100) begin
                errors++;
                $display("FAIL burst_write[%0d]: en=%b addr=%0d data=%h owner=%b expected 1/%0d/%h/0100",
                         k, bus_a.wr_en, bus_a.wr_addr, bus_a.wr_data, owner_a, 10 + k,
                         32'hA000_0000 + 32'(k));
            end
            checks++;
            if (dut.count_r !== 4'((k % 4) + 1)) begin
                errors++;
                $display("FAIL burst_count[%0d]: got %0d expected %0d", k, dut.count_r, (k % 4) + 1);
            end
        end
        bus_a.req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_zero_register();
        bus_a.req_valid = 4'b0001;
        set_a(0, 5'd0, 32'h0000_1234);
        tick();
        checks++;
        if (bus_a.wr_en !== 1'b0 || bus_a.wr_onehot !== 32'h0 || bus_a.wr_addr !== 5'd0
            || bus_a.wr_data !== 32'h0000_1234 || owner_a !== 4'b0001) begin
            errors++;
            $display("FAIL zero_reg: en=%b onehot=%h addr=%0d data=%h owner=%b expected 0/0/0/1234/0001",
                     bus_a.wr_en, bus_a.wr_onehot, bus_a.wr_addr, bus_a.wr_data, owner_a);
        end
        set_a(0, 5'd5, 32'h0000_0055);
        tick();
        checks++;
        if (dut.count_r !== 4'd2 || bus_a.wr_en !== 1'b1 || bus_a.wr_onehot !== 32'h0000_0020) begin
            errors++;
            $display("FAIL zero_reg_count: count=%0d en=%b onehot=%h expected 2/1/00000020",
                     dut.count_r, bus_a.wr_en, bus_a.wr_onehot);
        end
        bus_a.req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_owner_drop();
        bus_a.req_valid = 4'b0010;
        set_a(1, 5'd4, 32'h0000_0011);
        tick();
        tick();
        checks++;
        if (owner_a !== 4'b0010 || dut.count_r !== 4'd2) begin
            errors++;
            $display("FAIL drop_setup: owner=%b count=%0d expected 0010/2", owner_a, dut.count_r);
        end
        bus_a.req_valid = 4'b1000;
        set_a(3, 5'd6, 32'h0000_0033);
        #1;
        checks++;
        if (bus_a.req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL drop_ready: got %b expected 1000", bus_a.req_ready);
        end
        tick();
        checks++;
        if (bus_a.wr_en !== 1'b1 || bus_a.wr_addr !== 5'd6 || bus_a.wr_data !== 32'h0000_0033
            || owner_a !== 4'b1000) begin
            errors++;
            $display("FAIL drop_write: en=%b addr=%0d data=%h owner=%b expected 1/6/33/1000",
                     bus_a.wr_en, bus_a.wr_addr, bus_a.wr_data, owner_a);
        end
        bus_a.req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_contention();
        logic [3:0] exp_owner [5];
`ifdef ARB_ROUND_ROBIN_EN
        exp_owner = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
        exp_owner = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
`endif
        for (int i = 0; i < 4; i++) begin
            bus_b.req_addr[i*5 +: 5]   = 5'(i + 1);
            bus_b.req_data[i*32 +: 32] = 32'hB000_0000 + 32'(i);
        end
        bus_b.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (owner_b !== exp_owner[k] || bus_b.wr_en !== 1'b1) begin
                errors++;
                $display("FAIL contention[%0d]: owner=%b en=%b expected %b/1",
                         k, owner_b, bus_b.wr_en, exp_owner[k]);
            end
        end
        bus_b.req_valid = 4'b0000;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus_a.req_valid = 4'b0000;
        bus_a.req_addr  = 20'h0;
        bus_a.req_data  = 128'h0;
        bus_b.req_valid = 4'b0000;
        bus_b.req_addr  = 20'h0;
        bus_b.req_data  = 128'h0;
        test_reset();
        test_single();
        test_burst_limit();
        test_zero_register();
        test_owner_drop();
        test_contention();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
